// File: rtl/cpu_bus_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_serializer_pkg
//  Description : Shared types and constants for the CPU bus serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_serializer_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CMD  = 3'd2,
        S_WAIT = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Bit positions inside the command beat
    localparam int CMD_WE_BIT  = 0;
    localparam int CMD_STB_BIT = 1;

    // Strobe/direction flags of the command beat; the caller zero-extends to pin width
    function automatic logic [1:0] cmd_flags(input logic we);
        logic [1:0] f;
        f              = '0;
        f[CMD_STB_BIT] = 1'b1;
        f[CMD_WE_BIT]  = we;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_serializer_if
//  Description : CPU request bus plus narrow pin bus seen by the serializer.
//                master = CPU and pin-side environment, slave = serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_serializer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PIN_W  = 8
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              busy;
    // Pin side
    logic [PIN_W-1:0]  addr_pins;
    logic [PIN_W-1:0]  data_out;
    logic [PIN_W-1:0]  data_oe;
    logic [PIN_W-1:0]  data_in;
    logic              ext_rdy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, data_in, ext_rdy,
        input  cpu_rdata, cpu_ack, cpu_err, busy, addr_pins, data_out, data_oe
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, data_in, ext_rdy,
        output cpu_rdata, cpu_ack, cpu_err, busy, addr_pins, data_out, data_oe
    );

endinterface
`default_nettype wire

// File: rtl/cpu_bus_serializer_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_serializer_beat_counter
//  Description : Up counter with synchronous clear, enable and a terminal
//                count flag that compares against a run-time limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_serializer_beat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_last,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; clear has priority so a new phase always starts at 0
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (r_count == i_last);

endmodule
`default_nettype wire

// File: rtl/cpu_bus_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_serializer
//  Description : Bridges a parallel CPU request onto a narrow pin bus:
//                address beats, command beat, wait states with timeout, then
//                data beats, least-significant beat first. All outputs are
//                registered from the next-state decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_serializer
    import cpu_bus_serializer_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PIN_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_bus_serializer_if.slave  bus
);

    localparam int c_AB       = ADDR_W / PIN_W;
    localparam int c_DB       = DATA_W / PIN_W;
    localparam int c_BEAT_MAX = (c_AB > c_DB) ? c_AB : c_DB;
    localparam int c_BEAT_W   = $clog2(c_BEAT_MAX + 1);
    localparam int c_WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [c_BEAT_W-1:0] c_AB_LAST   = c_BEAT_W'(c_AB - 1);
    localparam logic [c_BEAT_W-1:0] c_DB_LAST   = c_BEAT_W'(c_DB - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);

    // Elaboration-time parameter sanity
    if ((ADDR_W % PIN_W) != 0) begin : g_chk_addr_w
        $error("cpu_bus_serializer: ADDR_W must be a multiple of PIN_W");
    end
    if ((DATA_W % PIN_W) != 0) begin : g_chk_data_w
        $error("cpu_bus_serializer: DATA_W must be a multiple of PIN_W");
    end
    if (WAIT_MAX < 1) begin : g_chk_wait_max
        $error("cpu_bus_serializer: WAIT_MAX must be >= 1");
    end
    if (PIN_W < 2) begin : g_chk_pin_w
        $error("cpu_bus_serializer: PIN_W must hold the strobe and we bits");
    end

    state_t              r_state, w_state_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr_sh, w_addr_sh_nxt;     // address beats still to send
    logic [DATA_W-1:0]   r_wdata_sh, w_wdata_sh_nxt;   // write beats still to send
    logic [DATA_W-1:0]   r_staging, w_staging_nxt;     // read beats shift in from the top
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_err, w_err_nxt;
    logic                r_busy;
    logic [PIN_W-1:0]    r_addr_pins, w_addr_pins_nxt;
    logic [PIN_W-1:0]    r_data_out, w_data_out_nxt;
    logic [PIN_W-1:0]    r_data_oe, w_data_oe_nxt;

    logic                w_beat_tc;
    logic                w_wait_tc;
    logic [c_BEAT_W-1:0] w_beat_last;

    assign w_beat_last = (r_state == S_ADDR) ? c_AB_LAST : c_DB_LAST;

    // Beat position inside ADDR and DATA; restarts on every state change
    cpu_bus_serializer_beat_counter #(.WIDTH(c_BEAT_W)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_state_nxt != r_state),
        .i_en   ((r_state == S_ADDR) || (r_state == S_DATA)),
        .i_last (w_beat_last),
        .o_tc   (w_beat_tc)
    );

    // Wait-state cycles; held at 0 outside WAIT so it starts fresh on entry
    cpu_bus_serializer_beat_counter #(.WIDTH(c_WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != S_WAIT),
        .i_en   (r_state == S_WAIT),
        .i_last (c_WAIT_LAST),
        .o_tc   (w_wait_tc)
    );

    // Next state plus the output values that state will present next cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_addr_sh_nxt   = r_addr_sh;
        w_wdata_sh_nxt  = r_wdata_sh;
        w_staging_nxt   = r_staging;
        w_rdata_nxt     = r_rdata;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_addr_pins_nxt = '0;
        w_data_out_nxt  = '0;
        w_data_oe_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_state_nxt     = S_ADDR;
                    w_we_nxt        = bus.cpu_we;
                    w_wdata_sh_nxt  = bus.cpu_wdata;
                    w_addr_pins_nxt = bus.cpu_addr[PIN_W-1:0];
                    w_addr_sh_nxt   = bus.cpu_addr >> PIN_W;
                end
            end
            S_ADDR: begin
                if (w_beat_tc) begin
                    w_state_nxt     = S_CMD;
                    w_addr_pins_nxt = PIN_W'(cmd_flags(r_we));
                end else begin
                    w_addr_pins_nxt = r_addr_sh[PIN_W-1:0];
                    w_addr_sh_nxt   = r_addr_sh >> PIN_W;
                end
            end
            S_CMD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Ready takes priority over a timeout in the same cycle
                if (bus.ext_rdy) begin
                    w_state_nxt = S_DATA;
                    if (r_we) begin
                        w_data_out_nxt = r_wdata_sh[PIN_W-1:0];
                        w_data_oe_nxt  = '1;
                        w_wdata_sh_nxt = r_wdata_sh >> PIN_W;
                    end
                end else if (w_wait_tc) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DATA: begin
                if (!r_we) begin
                    w_staging_nxt = (r_staging >> PIN_W)
                                  | (DATA_W'(bus.data_in) << (DATA_W - PIN_W));
                end
                if (w_beat_tc) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = w_staging_nxt;
                    end
                end else if (r_we) begin
                    w_data_out_nxt = r_wdata_sh[PIN_W-1:0];
                    w_data_oe_nxt  = '1;
                    w_wdata_sh_nxt = r_wdata_sh >> PIN_W;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, transfer context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr_sh   <= '0;
            r_wdata_sh  <= '0;
            r_staging   <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_addr_pins <= '0;
            r_data_out  <= '0;
            r_data_oe   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_addr_sh   <= w_addr_sh_nxt;
            r_wdata_sh  <= w_wdata_sh_nxt;
            r_staging   <= w_staging_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_addr_pins <= w_addr_pins_nxt;
            r_data_out  <= w_data_out_nxt;
            r_data_oe   <= w_data_oe_nxt;
        end
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ack   = r_ack;
    assign bus.cpu_err   = r_err;
    assign bus.busy      = r_busy;
    assign bus.addr_pins = r_addr_pins;
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_bus_serializer
//  Description : Self-checking bench: default-parameter instance exercised by
//                directed and random transfers against a cycle-indexed
//                reference model; a 16/16/4 instance for back-to-back writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_serializer;

    localparam int AB   = 4;
    localparam int DB   = 4;
    localparam int WMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_rdata_a = '0;

    always #5 clk = ~clk;

    cpu_bus_serializer_if #(.ADDR_W(32), .DATA_W(32), .PIN_W(8)) bus_a ();
    cpu_bus_serializer_if #(.ADDR_W(16), .DATA_W(16), .PIN_W(4)) bus_b ();

    cpu_bus_serializer #(.ADDR_W(32), .DATA_W(32), .PIN_W(8), .WAIT_MAX(WMAX)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    cpu_bus_serializer #(.ADDR_W(16), .DATA_W(16), .PIN_W(4), .WAIT_MAX(WMAX)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // One transfer on instance A. d = ext_rdy-low WAIT cycles (>= WMAX means never ready).
    // abort_at > 0 pulses reset during that cycle and checks the transfer is dropped.
    task automatic test_transfer(input string name, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rbeats,
                                 input int d, input int abort_at);
        bit   tmo;
        int   wc, ack_c, j;
        logic [7:0] e_pins, e_dout, e_oe;
        logic e_ack, e_err;
        tmo   = (d >= WMAX);
        wc    = tmo ? WMAX : d + 1;
        ack_c = tmo ? AB + 2 + WMAX : AB + DB + 2 + wc;
        @(negedge clk);
        bus_a.cpu_req   = 1'b1;
        bus_a.cpu_we    = we;
        bus_a.cpu_addr  = addr;
        bus_a.cpu_wdata = wdata;
        @(posedge clk);
        for (int c = 1; c <= ack_c; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus_a.cpu_req   = 1'b0;
                bus_a.cpu_we    = 1'($urandom);
                bus_a.cpu_addr  = $urandom;
                bus_a.cpu_wdata = $urandom;
            end
            j = c - (AB + 2 + wc);
            if (c < AB + 2) bus_a.ext_rdy = 1'($urandom);
            else            bus_a.ext_rdy = (!tmo && c >= AB + 2 + d);
            if (!tmo && j >= 0 && j < DB) bus_a.data_in = 8'(rbeats >> (8 * j));
            else                          bus_a.data_in = 8'($urandom);
            e_pins = '0; e_dout = '0; e_oe = '0; e_ack = 1'b0; e_err = 1'b0;
            if (c <= AB)                e_pins = 8'(addr >> (8 * (c - 1)));
            else if (c == AB + 1)       e_pins = we ? 8'h03 : 8'h02;
            else if (c == ack_c) begin
                e_ack = 1'b1;
                e_err = tmo;
                if (!tmo && !we) exp_rdata_a = rbeats;
            end else if (c > AB + 1 + wc) begin
                e_oe   = we ? 8'hFF : 8'h00;
                e_dout = we ? 8'(wdata >> (8 * j)) : 8'h00;
            end
            if (bus_a.addr_pins !== e_pins) begin errors++; $display("FAIL %s c%0d addr_pins got %h exp %h", name, c, bus_a.addr_pins, e_pins); end
            checks++;
            if (bus_a.data_out !== e_dout) begin errors++; $display("FAIL %s c%0d data_out got %h exp %h", name, c, bus_a.data_out, e_dout); end
            checks++;
            if (bus_a.data_oe !== e_oe) begin errors++; $display("FAIL %s c%0d data_oe got %h exp %h", name, c, bus_a.data_oe, e_oe); end
            checks++;
            if (bus_a.cpu_ack !== e_ack) begin errors++; $display("FAIL %s c%0d cpu_ack got %b exp %b", name, c, bus_a.cpu_ack, e_ack); end
            checks++;
            if (bus_a.cpu_err !== e_err) begin errors++; $display("FAIL %s c%0d cpu_err got %b exp %b", name, c, bus_a.cpu_err, e_err); end
            checks++;
            if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL %s c%0d busy got %b exp 1", name, c, bus_a.busy); end
            checks++;
            if (bus_a.cpu_rdata !== exp_rdata_a) begin errors++; $display("FAIL %s c%0d cpu_rdata got %h exp %h", name, c, bus_a.cpu_rdata, exp_rdata_a); end
            checks++;
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                exp_rdata_a = '0;
                if ({bus_a.busy, bus_a.cpu_ack, bus_a.cpu_err} !== 3'b000) begin errors++; $display("FAIL %s_rst busy/ack/err got %b exp 000", name, {bus_a.busy, bus_a.cpu_ack, bus_a.cpu_err}); end
                checks++;
                if ({bus_a.data_oe, bus_a.data_out, bus_a.addr_pins} !== 24'h0) begin errors++; $display("FAIL %s_rst oe/dout/pins got %h exp 0", name, {bus_a.data_oe, bus_a.data_out, bus_a.addr_pins}); end
                checks++;
                if (bus_a.cpu_rdata !== exp_rdata_a) begin errors++; $display("FAIL %s_rst cpu_rdata got %h exp %h", name, bus_a.cpu_rdata, exp_rdata_a); end
                checks++;
                return;
            end
        end
        @(negedge clk);
        if ({bus_a.busy, bus_a.cpu_ack} !== 2'b00) begin errors++; $display("FAIL %s idle busy/ack got %b exp 00", name, {bus_a.busy, bus_a.cpu_ack}); end
        checks++;
        if (bus_a.cpu_rdata !== exp_rdata_a) begin errors++; $display("FAIL %s idle cpu_rdata got %h exp %h", name, bus_a.cpu_rdata, exp_rdata_a); end
        checks++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if ({bus_a.busy, bus_a.cpu_ack, bus_a.cpu_err} !== 3'b000) begin errors++; $display("FAIL reset busy/ack/err got %b exp 000", {bus_a.busy, bus_a.cpu_ack, bus_a.cpu_err}); end
        checks++;
        if ({bus_a.addr_pins, bus_a.data_out, bus_a.data_oe} !== 24'h0) begin errors++; $display("FAIL reset pins/dout/oe got %h exp 0", {bus_a.addr_pins, bus_a.data_out, bus_a.data_oe}); end
        checks++;
        if (bus_a.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset cpu_rdata got %h exp 0", bus_a.cpu_rdata); end
        checks++;
        if ({bus_b.busy, bus_b.cpu_ack, bus_b.data_oe} !== 6'h0) begin errors++; $display("FAIL reset_b busy/ack/oe got %h exp 0", {bus_b.busy, bus_b.cpu_ack, bus_b.data_oe}); end
        checks++;
    endtask

    task automatic test_write();
        test_transfer("write", 1'b1, 32'h12345678, 32'hCAFEF00D, 32'h0, 0, 0);
    endtask

    task automatic test_read();
        test_transfer("read", 1'b0, 32'h00000004, 32'h0, 32'h44332211, 0, 0);
    endtask

    task automatic test_wait_states();
        test_transfer("wait_wr", 1'b1, 32'hA5A55A5A, 32'h01234567, 32'h0, 3, 0);
        test_transfer("wait_rd", 1'b0, 32'h0000F00C, 32'h0, 32'h89ABCDEF, 3, 0);
    endtask

    task automatic test_timeout();
        test_transfer("tmo_rd", 1'b0, 32'h00000040, 32'h0, 32'hDEADBEEF, WMAX, 0);
        test_transfer("tmo_wr", 1'b1, 32'h00000080, 32'h55AA55AA, 32'h0, WMAX + 5, 0);
        test_transfer("rdy_wins", 1'b0, 32'h00000100, 32'h0, 32'h13579BDF, WMAX - 1, 0);
    endtask

    task automatic test_reset_mid();
        test_transfer("rst_mid", 1'b1, 32'hFEEDC0DE, 32'h87654321, 32'h0, 0, AB + 2 + 1 + 2);
        test_transfer("after_rst", 1'b1, 32'h0BADF00D, 32'h24681357, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            test_transfer("random", 1'($urandom), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 17)), 0);
        end
    endtask

    // Instance B: req held high across two writes; acks must be 12 cycles apart
    task automatic test_back_to_back();
        logic [15:0] a0, a1, w0, w1, ca, cw;
        logic [3:0]  e_pins, e_dout, e_oe;
        logic        e_ack, e_busy;
        int          cl, last_ack, n_ack;
        a0 = 16'($urandom); a1 = 16'($urandom);
        w0 = 16'($urandom); w1 = 16'($urandom);
        last_ack = -1; n_ack = 0;
        @(negedge clk);
        bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b1;
        bus_b.cpu_addr = a0;  bus_b.cpu_wdata = w0;
        bus_b.ext_rdy = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 2) begin bus_b.cpu_addr = a1; bus_b.cpu_wdata = w1; end
            if (c == 13) bus_b.cpu_req = 1'b0;
            bus_b.data_in = 4'($urandom);
            if (c <= 11) begin cl = c;      ca = a0; cw = w0; end
            else         begin cl = c - 12; ca = a1; cw = w1; end
            e_busy = !(c == 12 || c >= 24);
            e_pins = '0; e_dout = '0; e_oe = '0; e_ack = 1'b0;
            if (e_busy) begin
                if (cl <= 4)                 e_pins = 4'(ca >> (4 * (cl - 1)));
                else if (cl == 5)            e_pins = 4'h3;
                else if (cl >= 7 && cl <= 10) begin e_oe = 4'hF; e_dout = 4'(cw >> (4 * (cl - 7))); end
                else if (cl == 11)           e_ack = 1'b1;
            end
            if (bus_b.addr_pins !== e_pins) begin errors++; $display("FAIL b2b c%0d addr_pins got %h exp %h", c, bus_b.addr_pins, e_pins); end
            checks++;
            if ({bus_b.data_oe, bus_b.data_out} !== {e_oe, e_dout}) begin errors++; $display("FAIL b2b c%0d oe/dout got %h exp %h", c, {bus_b.data_oe, bus_b.data_out}, {e_oe, e_dout}); end
            checks++;
            if ({bus_b.busy, bus_b.cpu_ack, bus_b.cpu_err} !== {e_busy, e_ack, 1'b0}) begin errors++; $display("FAIL b2b c%0d busy/ack/err got %b exp %b", c, {bus_b.busy, bus_b.cpu_ack, bus_b.cpu_err}, {e_busy, e_ack, 1'b0}); end
            checks++;
            if (bus_b.cpu_ack === 1'b1) begin
                n_ack++;
                if (last_ack >= 0) begin
                    if (c - last_ack !== 12) begin errors++; $display("FAIL b2b ack_spacing got %0d exp 12", c - last_ack); end
                    checks++;
                end
                last_ack = c;
            end
        end
        if (n_ack !== 2) begin errors++; $display("FAIL b2b ack_count got %0d exp 2", n_ack); end
        checks++;
        if (bus_b.cpu_rdata !== 16'h0) begin errors++; $display("FAIL b2b cpu_rdata got %h exp 0", bus_b.cpu_rdata); end
        checks++;
    endtask

    initial begin
        bus_a.cpu_req = 1'b0; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
        bus_a.data_in = '0;   bus_a.ext_rdy = 1'b0;
        bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
        bus_b.data_in = '0;   bus_b.ext_rdy = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
